// File: rtl/coef_stream_tx.sv
// coef_stream_tx
// Transmit side of the coefficient-load interface. On a single-cycle start
// request the coefficient table is snapshotted, the receiver is cleared, and
// the words are streamed in order coef[0]..coef[N_COEF-1], one strobe each,
// with GAP hold cycles after every strobe. A one-cycle done pulse follows the
// last hold phase; an abort returns to idle without a done pulse.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   coef_bus_i coefficient table, coef[k] = coef_bus_i[k*W +: W]
//   start_i    start request, sampled only when idle
//   abort_i    abort the stream in progress (ignored in idle and done)
//   coef_o     coefficient word to receiver
//   clear_o    one-cycle receiver clear before the first word
//   en_tx_o    receive enable, high for the whole data phase
//   strobe_o   one-cycle coefficient-change strobe
//   busy_o     high while not idle
//   done_o     one-cycle completion pulse
module coef_stream_tx #(
    parameter int unsigned N_COEF = 16,
    parameter int unsigned W      = 12,
    parameter int unsigned GAP    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_COEF*W-1:0] coef_bus_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic [W-1:0]        coef_o,
    output logic                clear_o,
    output logic                en_tx_o,
    output logic                strobe_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned IW = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam int unsigned GW = $clog2(GAP + 1);

    localparam logic [IW-1:0] LastIdx  = IW'(N_COEF - 1);
    localparam logic [GW-1:0] GapStart = GW'(GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSetup,
        StStrobe,
        StHold,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [N_COEF*W-1:0]   snap_q, snap_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [GW-1:0]         gap_q, gap_d;

    logic [W-1:0]          coef_q, coef_d;
    logic                  clear_q, clear_d;
    logic                  en_q, en_d;
    logic                  strobe_q, strobe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        gap_d   = gap_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    snap_d  = coef_bus_i;
                    state_d = StClear;
                end
            end
            StClear: begin
                idx_d   = '0;
                state_d = StSetup;
            end
            StSetup: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                gap_d   = GapStart;
                state_d = StHold;
            end
            StHold: begin
                if (gap_q == '0) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSetup;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort only cuts an active stream; the done pulse is never suppressed.
        if (abort_i && (state_q inside {StClear, StSetup, StStrobe, StHold})) begin
            state_d = StIdle;
        end

        // Outputs are registered, so decode them from the next state.
        clear_d  = (state_d == StClear);
        en_d     = (state_d inside {StSetup, StStrobe, StHold});
        strobe_d = (state_d == StStrobe);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);

        if (state_d == StSetup) begin
            coef_d = snap_q[W*int'(idx_d) +: W];
        end else if (en_d) begin
            coef_d = coef_q;
        end else begin
            coef_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            snap_q   <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            coef_q   <= '0;
            clear_q  <= 1'b0;
            en_q     <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            coef_q   <= coef_d;
            clear_q  <= clear_d;
            en_q     <= en_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign coef_o   = coef_q;
    assign clear_o  = clear_q;
    assign en_tx_o  = en_q;
    assign strobe_o = strobe_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_coef_stream_tx.sv
// Testbench for coef_stream_tx: a driver issues directed streams and pushes
// the expected clear/strobe/done events into a scoreboard queue; a monitor
// pops and compares every event the DUTs present. Instance 0 uses the
// default parameters, instance 1 uses N_COEF=2, GAP=1.
module tb_coef_stream_tx;

    typedef struct {
        int inst;
        int kind;   // 0 clear, 1 strobe, 2 done
        int cyc;
        int val;
    } ev_t;

    logic          clk;
    logic          rst;
    logic [191:0]  bus0;
    logic [23:0]   bus1;
    logic          start_a  [2];
    logic          abort_a  [2];
    logic [11:0]   coef_a   [2];
    logic          clear_a  [2];
    logic          en_a     [2];
    logic          strobe_a [2];
    logic          busy_a   [2];
    logic          done_a   [2];

    int  cyc = 0;
    int  n_err = 0;
    int  n_checks = 0;
    int  gap_of [2] = '{4, 1};
    ev_t exp_q [$];

    coef_stream_tx u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .coef_bus_i (bus0),
        .start_i    (start_a[0]),
        .abort_i    (abort_a[0]),
        .coef_o     (coef_a[0]),
        .clear_o    (clear_a[0]),
        .en_tx_o    (en_a[0]),
        .strobe_o   (strobe_a[0]),
        .busy_o     (busy_a[0]),
        .done_o     (done_a[0])
    );

    coef_stream_tx #(
        .N_COEF (2),
        .W      (12),
        .GAP    (1)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .coef_bus_i (bus1),
        .start_i    (start_a[1]),
        .abort_i    (abort_a[1]),
        .coef_o     (coef_a[1]),
        .clear_o    (clear_a[1]),
        .en_tx_o    (en_a[1]),
        .strobe_o   (strobe_a[1]),
        .busy_o     (busy_a[1]),
        .done_o     (done_a[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic got_event(input int inst, input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event at cycle %0d: got inst %0d kind %0d, expected none",
                     cyc, inst, kind);
        end else begin
            e = exp_q.pop_front();
            chk("ev_inst", inst, e.inst);
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_value", val, e.val);
        end
    endtask

    // Monitor: compares every DUT event against the scoreboard front.
    initial begin
        int        hold_left [2];
        logic [11:0] held    [2];
        logic [11:0] prev    [2];
        for (int i = 0; i < 2; i++) begin
            hold_left[i] = 0;
            held[i]      = '0;
            prev[i]      = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (clear_a[i]) got_event(i, 0, 0);
                if (strobe_a[i]) begin
                    chk("coef_before_strobe", int'(prev[i]), int'(coef_a[i]));
                    chk("en_at_strobe", int'(en_a[i]), 1);
                    got_event(i, 1, int'(coef_a[i]));
                    hold_left[i] = gap_of[i];
                    held[i]      = coef_a[i];
                end else if (en_a[i] && hold_left[i] > 0) begin
                    chk("hold_coef", int'(coef_a[i]), int'(held[i]));
                    hold_left[i]--;
                end
                if (!en_a[i]) hold_left[i] = 0;
                if (done_a[i]) begin
                    chk("done_coef", int'(coef_a[i]), 0);
                    chk("done_en", int'(en_a[i]), 0);
                    chk("done_busy", int'(busy_a[i]), 1);
                    got_event(i, 2, 0);
                end
                prev[i] = coef_a[i];
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_start(input int i);
        start_a[i] = 1'b1;
        @(negedge clk);
        start_a[i] = 1'b0;
    endtask

    // fill < 0 means word k carries base+k.
    task automatic push_stream(input int inst, input int c0, input int n, input int g,
                               input int nstr, input bit with_done, input int base,
                               input int fill);
        exp_q.push_back('{inst, 0, c0 + 1, 0});
        for (int k = 0; k < nstr; k++) begin
            exp_q.push_back('{inst, 1, c0 + 3 + (2 + g) * k, (fill >= 0) ? fill : base + k});
        end
        if (with_done) exp_q.push_back('{inst, 2, c0 + 2 + (2 + g) * n, 0});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) bus0[k*12 +: 12] = 12'(12'h100 + k);
    endtask

    task automatic chk_idle(input string name, input int i);
        chk(name, int'({coef_a[i], clear_a[i], en_a[i], strobe_a[i], busy_a[i], done_a[i]}), 0);
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0;
            abort_a[i] = 1'b0;
        end
        set_ramp();
        bus1 = {12'h7F1, 12'h7F0};
        repeat (3) @(negedge clk);
        chk_idle("reset_outputs0", 0);
        chk_idle("reset_outputs1", 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Stream with snapshot change, ignored restarts, then back-to-back start.
        c0 = cyc;
        push_stream(0, c0, 16, 4, 16, 1, 12'h100, -1);
        pulse_start(0);
        chk("busy_cycle1", int'(busy_a[0]), 1);
        wait_cyc(c0 + 5);
        bus0 = '1;
        wait_cyc(c0 + 10);
        pulse_start(0);
        wait_cyc(c0 + 50);
        pulse_start(0);
        wait_cyc(c0 + 99);
        push_stream(0, c0 + 99, 16, 4, 16, 1, 0, 12'hFFF);
        pulse_start(0);
        drain();

        // Abort in the hold phase of word 6.
        set_ramp();
        c0 = cyc;
        push_stream(0, c0, 16, 4, 7, 0, 12'h100, -1);
        pulse_start(0);
        wait_cyc(c0 + 40);
        abort_a[0] = 1'b1;
        @(negedge clk);
        abort_a[0] = 1'b0;
        chk_idle("after_abort", 0);
        drain();
        c0 = cyc;
        push_stream(0, c0, 16, 4, 16, 1, 12'h100, -1);
        pulse_start(0);
        drain();

        // Asynchronous reset mid-stream, checked before the next clock edge.
        c0 = cyc;
        push_stream(0, c0, 16, 4, 5, 0, 12'h100, -1);
        pulse_start(0);
        wait_cyc(c0 + 30);
        #1 rst = 1'b1;
        #1 chk_idle("async_reset", 0);
        @(negedge clk);
        rst = 1'b0;
        drain();
        c0 = cyc;
        push_stream(0, c0, 16, 4, 16, 1, 12'h100, -1);
        pulse_start(0);
        drain();

        // Small configuration: strobes at 3 and 6, done at 8.
        c0 = cyc;
        push_stream(1, c0, 2, 1, 2, 1, 12'h7F0, -1);
        pulse_start(1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
